// File: rtl/stream_fifo.sv
// stream_fifo: single-clock first-word-fall-through FIFO with valid/ready
// handshakes on both sides.
// - DEPTH may be any integer >= 2. The read and write pointers wrap
//   explicitly from DEPTH-1 back to 0.
// - size and afull are registered. iready and ovalid are decoded from
//   registered state only.
// - Optional synchronous flush port, enabled by defining STREAM_FIFO_FLUSH_EN.
module stream_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 7,
  parameter  int AFULL = DEPTH - 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             resetn,
`ifdef STREAM_FIFO_FLUSH_EN
  input  logic             flush,
`endif
  input  logic [WIDTH-1:0] idata,
  input  logic             ivalid,
  output logic             iready,
  output logic [WIDTH-1:0] odata,
  output logic             ovalid,
  input  logic             oready,
  output logic [CW-1:0]    size,
  output logic             afull
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    size_q, size_d;
  logic             afull_q, afull_d;
  logic             push, pop, clear, wr_en;

  // Pointer increment with an explicit wrap, so non-power-of-two depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

`ifdef STREAM_FIFO_FLUSH_EN
  assign clear = flush;
`else
  assign clear = 1'b0;
`endif

  // Handshake flags come only from the registered occupancy.
  assign iready = (size_q != CW'(DEPTH));
  assign ovalid = (size_q != '0);
  assign push   = ivalid && iready;
  assign pop    = ovalid && oready;
  assign wr_en  = push && !clear;
  assign odata  = mem_q[rd_ptr_q];
  assign size   = size_q;
  assign afull  = afull_q;

  // Next-state logic for the pointers, occupancy and almost-full flag.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    size_d   = size_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      size_d   = '0;
    end else begin
      if (push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   size_d = size_q + CW'(1);
        2'b01:   size_d = size_q - CW'(1);
        default: size_d = size_q;
      endcase
    end
    afull_d = (size_d >= CW'(AFULL));
  end

  // Control state register; reset empties the queue immediately.
  always_ff @(posedge clock or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the pre-edge values of its inputs.
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      size_q   <= '0;
      afull_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      size_q   <= size_d;
      afull_q  <= afull_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clock) begin
    // NOTE: the data array has no reset. Words are only observable once size
    // covers them, so stale contents after reset are harmless.
    if (wr_en) mem_q[wr_ptr_q] <= idata;
  end

endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo.
// - Three instances with DEPTH = 7, 5 and 8. Each instance is compared every
//   cycle against its own queue-based reference model.
// - Directed fill, stream and drain sequences run on the DEPTH=7 instance.
// - A randomized handshake run drives all three instances.
// - A mid-cycle asynchronous reset is applied to all three.
// - A flush test runs when STREAM_FIFO_FLUSH_EN is defined.
module tb_stream_fifo;

  localparam int N = 3;

  logic clock = 1'b0;
  logic resetn;
  logic flush;

  logic [7:0] idata  [N];
  logic       ivalid [N];
  logic       iready [N];
  logic [7:0] odata  [N];
  logic       ovalid [N];
  logic       oready [N];
  logic       afull  [N];
  logic [2:0] size7;
  logic [2:0] size5;
  logic [3:0] size8;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] model_q  [N][$];
  logic [7:0] last_pop [N];
  bit         accepted [N];
  int         pushes   [N];
  int         next_data;

  always #5 clock = ~clock;

  stream_fifo #(.WIDTH(8), .DEPTH(7)) u_fifo7 (
    .clock(clock), .resetn(resetn),
`ifdef STREAM_FIFO_FLUSH_EN
    .flush(flush),
`endif
    .idata(idata[0]), .ivalid(ivalid[0]), .iready(iready[0]),
    .odata(odata[0]), .ovalid(ovalid[0]), .oready(oready[0]),
    .size(size7), .afull(afull[0])
  );

  stream_fifo #(.WIDTH(8), .DEPTH(5)) u_fifo5 (
    .clock(clock), .resetn(resetn),
`ifdef STREAM_FIFO_FLUSH_EN
    .flush(flush),
`endif
    .idata(idata[1]), .ivalid(ivalid[1]), .iready(iready[1]),
    .odata(odata[1]), .ovalid(ovalid[1]), .oready(oready[1]),
    .size(size5), .afull(afull[1])
  );

  stream_fifo #(.WIDTH(8), .DEPTH(8)) u_fifo8 (
    .clock(clock), .resetn(resetn),
`ifdef STREAM_FIFO_FLUSH_EN
    .flush(flush),
`endif
    .idata(idata[2]), .ivalid(ivalid[2]), .iready(iready[2]),
    .odata(odata[2]), .ovalid(ovalid[2]), .oready(oready[2]),
    .size(size8), .afull(afull[2])
  );

  function automatic int depth_of(input int i);
    case (i)
      0:       return 7;
      1:       return 5;
      default: return 8;
    endcase
  endfunction

  function automatic logic [31:0] size_of(input int i);
    case (i)
      0:       return 32'(size7);
      1:       return 32'(size5);
      default: return 32'(size8);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every instance's outputs against its reference queue.
  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      int sz;
      sz = model_q[i].size();
      check($sformatf("size[%0d]", i),   size_of(i),       32'(sz));
      check($sformatf("ovalid[%0d]", i), 32'(ovalid[i]),   32'(sz != 0));
      check($sformatf("iready[%0d]", i), 32'(iready[i]),   32'(sz != depth_of(i)));
      check($sformatf("afull[%0d]", i),  32'(afull[i]),    32'(sz >= depth_of(i) - 1));
      if (sz != 0) check($sformatf("odata[%0d]", i), 32'(odata[i]), 32'(model_q[i][0]));
    end
  endtask

  // One clock: decide handshakes from the model, apply the edge, then check.
  task automatic step();
    bit do_push [N];
    bit do_pop  [N];
    bit do_flush;
    do_flush = flush;
    for (int i = 0; i < N; i++) begin
      do_push[i]  = ivalid[i] && (model_q[i].size() < depth_of(i));
      do_pop[i]   = oready[i] && (model_q[i].size() > 0);
      accepted[i] = do_push[i] && !do_flush;
    end
    @(posedge clock);
    for (int i = 0; i < N; i++) begin
      if (do_flush) begin
        model_q[i].delete();
      end else begin
        if (do_pop[i])  last_pop[i] = model_q[i].pop_front();
        if (do_push[i]) begin
          model_q[i].push_back(idata[i]);
          pushes[i]++;
        end
      end
    end
    @(negedge clock);
    check_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // NOTE: bench stimulus is driven with blocking assignments from this
    // initial block, always away from the rising edge.
    resetn = 1'b0;
    flush  = 1'b0;
    for (int i = 0; i < N; i++) begin
      ivalid[i] = 1'b0; oready[i] = 1'b0; idata[i] = '0;
      pushes[i] = 0;    last_pop[i] = '0; accepted[i] = 1'b0;
    end
    repeat (2) @(negedge clock);
    check_all();
    check("rst_iready", 32'(iready[0]), 32'd1);
    resetn = 1'b1;

    // Fill: push 0,1,2,... with no consumer for 10 cycles.
    next_data = 0;
    ivalid[0] = 1'b1;
    idata[0]  = 8'(next_data);
    repeat (10) begin
      step();
      if (accepted[0]) next_data++;
      idata[0] = 8'(next_data);
    end
    check("fill_size",   32'(size7),     32'd7);
    check("fill_iready", 32'(iready[0]), 32'd0);
    check("fill_afull",  32'(afull[0]),  32'd1);
    check("fill_ovalid", 32'(ovalid[0]), 32'd1);
    check("fill_odata",  32'(odata[0]),  32'd0);

    // Stream: the consumer starts while full and the producer keeps pushing.
    oready[0] = 1'b1;
    step();
    if (accepted[0]) next_data++;
    idata[0] = 8'(next_data);
    check("pop1_size", 32'(size7), 32'd6);
    repeat (8) begin
      step();
      if (accepted[0]) next_data++;
      idata[0] = 8'(next_data);
    end
    check("stream_size", 32'(size7),     32'd6);
    check("stream_head", 32'(odata[0]),  32'd9);

    // Drain: the producer stops; the queue empties in order.
    ivalid[0] = 1'b0;
    for (int k = 0; k < 20 && model_q[0].size() > 0; k++) step();
    check("drain_ovalid", 32'(ovalid[0]),   32'd0);
    check("drain_size",   32'(size7),       32'd0);
    check("drain_last",   32'(last_pop[0]), 32'd14);
    oready[0] = 1'b0;

    // Random traffic on all instances; the producer holds a rejected word.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      int wp, wr;
      wp = ((cyc / 2500) % 2 == 0) ? 70 : 40;
      wr = ((cyc / 2500) % 2 == 0) ? 40 : 70;
      for (int i = 0; i < N; i++) begin
        if (!(ivalid[i] && !accepted[i])) begin
          ivalid[i] = ($urandom_range(99) < wp);
          idata[i]  = 8'($urandom);
        end
        oready[i] = ($urandom_range(99) < wr);
      end
      step();
    end
    for (int i = 0; i < N; i++) begin
      check($sformatf("rand_traffic[%0d]", i), 32'(pushes[i] > 1000), 32'd1);
      ivalid[i] = 1'b0;
      oready[i] = 1'b1;
    end
    repeat (10) step();
    for (int i = 0; i < N; i++) oready[i] = 1'b0;

    // Asynchronous reset between edges while four words are stored.
    ivalid[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      idata[0] = 8'(8'h10 + k);
      step();
    end
    ivalid[0] = 1'b0;
    check("pre_rst_size", 32'(size7), 32'd4);
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_size",   32'(size7),     32'd0);
    check("mid_rst_ovalid", 32'(ovalid[0]), 32'd0);
    check("mid_rst_iready", 32'(iready[0]), 32'd1);
    check("mid_rst_afull",  32'(afull[0]),  32'd0);
    resetn = 1'b1;
    for (int i = 0; i < N; i++) model_q[i].delete();
    @(negedge clock);
    ivalid[0] = 1'b1;
    idata[0]  = 8'hA5;
    step();
    ivalid[0] = 1'b0;
    check("post_rst_odata", 32'(odata[0]), 32'hA5);
    check("post_rst_size",  32'(size7),    32'd1);

`ifdef STREAM_FIFO_FLUSH_EN
    // Flush with a simultaneous push and pop discards everything.
    oready[0] = 1'b1;
    repeat (3) step();
    oready[0] = 1'b0;
    ivalid[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      idata[0] = 8'(8'h30 + k);
      step();
    end
    check("pre_flush_size", 32'(size7), 32'd3);
    idata[0]  = 8'h77;
    oready[0] = 1'b1;
    flush     = 1'b1;
    step();
    flush     = 1'b0;
    ivalid[0] = 1'b0;
    oready[0] = 1'b0;
    check("flush_size",   32'(size7),     32'd0);
    check("flush_ovalid", 32'(ovalid[0]), 32'd0);
    step();
    check("flush_discard", 32'(size7), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
